// File: rtl/counter_div_ctrl_pkg.sv
// Shared types and helpers for the modulo-N divider control stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package counter_div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Terminal count of the downstream 4-bit counter.
  localparam logic [3:0] CNT_TC = 4'hF;

  // Preset so the counter reaches CNT_TC after n-1 increments: (16 - n) mod 16.
  // n = 0 encodes 16 and yields a preset of 0.
  function automatic logic [3:0] preset(input logic [3:0] n);
    return 4'd0 - n;
  endfunction

endpackage

// File: rtl/counter_div_ctrl.sv
// Control stage driving a 4-bit loadable counter as a programmable modulo-N divider with burst/free-run.
// Latency: first tick N+1 cycles after the start edge, then every N unpaused cycles; tick/done registered.
// Backpressure: pause freezes the counter (no reload, no tick); abort returns to IDLE; start ignored while busy.
module counter_div_ctrl
  import counter_div_ctrl_pkg::*;
#(
  parameter int BURST_W = 8
) (
  input  logic               CLK,
  input  logic               CLR_n,
  input  logic               start,
  input  logic               abort,
  input  logic               pause,
  input  logic [3:0]         div_n,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [3:0]         cnt_Q,
  output logic [3:0]         cnt_D,
  output logic               cnt_LOAD_n,
  output logic               cnt_ENP,
  output logic               cnt_ENT,
  output logic               tick,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] periods_done
);

  state_e               state_q, state_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic [BURST_W-1:0]   periods_q, periods_d;
  logic [BURST_W-1:0]   periods_inc;
  logic [3:0]           cnt_d_q, cnt_d_d;
  logic                 tick_q, tick_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 load_q, load_d;
  logic                 run_q, run_d;
  logic                 wrap;

  // Wrap: counter sits at terminal count in RUN and is not frozen; it is reloaded instead of rolling over.
  assign wrap        = run_q && (cnt_Q == CNT_TC) && !pause;
  assign periods_inc = periods_q + BURST_W'(1);

  // Next-state and next-output decode.
  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    periods_d = periods_q;
    cnt_d_d   = cnt_d_q;
    tick_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          burst_d   = burst_len;
          cnt_d_d   = preset(div_n);
          periods_d = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        state_d = abort ? IDLE : RUN;
      end
      RUN: begin
        if (abort) begin
          // Abort wins over a coincident wrap: no tick, periods_done holds.
          state_d = IDLE;
        end else if (wrap) begin
          periods_d = periods_inc;
          tick_d    = 1'b1;
          if ((burst_q != '0) && (periods_inc == burst_q)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == LOAD) || (state_d == RUN);
    load_d = (state_d == LOAD);
    run_d  = (state_d == RUN);
  end

  // State and registered outputs; async clear returns everything to idle values.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q   <= IDLE;
      burst_q   <= '0;
      periods_q <= '0;
      cnt_d_q   <= 4'd0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      load_q    <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      periods_q <= periods_d;
      cnt_d_q   <= cnt_d_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      load_q    <= load_d;
      run_q     <= run_d;
    end
  end

  // Counter enables follow pause immediately so the count never advances past CNT_TC unreloaded.
  assign cnt_D        = cnt_d_q;
  assign cnt_LOAD_n   = !load_q && !wrap;
  assign cnt_ENT      = run_q;
  assign cnt_ENP      = run_q && !pause;
  assign tick         = tick_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign periods_done = periods_q;

endmodule
